crystal_pixel_feeder: RTL and testbench
=======================================

CRYSTAL_PIXEL_FEEDER -- requirements
Module: crystal_pixel_feeder

Interface
REQ-001 SHALL have parameter INPUT_DIM, default 784, pixels per frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of the signed pixel word driven to the network.
REQ-003 SHALL have parameter ZERO_POINT, default 128, unsigned offset subtracted from each raw pixel.
REQ-004 SHALL have parameter FRAC_SHIFT, default 0, left shift applied after offset removal; legal range 0..DATA_WIDTH-9.
REQ-005 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, all logic rising-edge.
  rst  in  1  reset, synchronous and active-high.
  s_valid  in  1  raw pixel beat valid.
  s_ready  out  1  feeder accepts beat.
  s_data  in  8  raw unsigned pixel.
  s_last  in  1  final beat of source frame.
  res_valid  in  1  network result strobe, i.e. the network's valid_out.
  px_valid  out  1  pixel word valid to network.
  px_data  out  DATA_WIDTH  signed pixel word.
  px_idx  out  $clog2(INPUT_DIM)  pixel index 0..INPUT_DIM-1.
  px_last  out  1  asserted with px_idx = INPUT_DIM-1.
  busy  out  1  frame in progress or result pending.
  frame_err  out  1  sticky framing-error flag.
  err_clr  in  1  clears frame_err.
  frame_cnt  out  16  frames delivered to network.

Function
REQ-006 SHALL implement the states STREAM, PAD, DROP and WAIT, with a pixel counter idx.
REQ-007 SHALL drive s_ready = 1 in STREAM and DROP, and s_ready = 0 in PAD and WAIT; a beat is accepted when s_valid and s_ready are both high.
REQ-008 SHALL register all px_* outputs: a beat accepted in cycle N appears on px_* in cycle N+1 with px_valid = 1.
REQ-009 SHALL hold px_valid = 0 in any cycle following a cycle with no accepted or pad beat; gaps in the pixel stream are legal.
REQ-010 SHALL compute px_data = (signed 9-bit (s_data - ZERO_POINT)) sign-extended to DATA_WIDTH, then arithmetically shifted left by FRAC_SHIFT, with no saturation.
REQ-011 SHALL set px_idx to the value of idx for the accepted beat, then increment idx.
REQ-012 In STREAM, a beat with idx < INPUT_DIM-1 and s_last = 0 SHALL emit a normal pixel and remain in STREAM.
REQ-013 In STREAM, a beat with idx = INPUT_DIM-1 and s_last = 1 SHALL emit the pixel with px_last = 1 and move to WAIT.
REQ-014 In STREAM, a beat with idx < INPUT_DIM-1 and s_last = 1 (early end) SHALL emit the pixel with px_last = 0, set frame_err, and move to PAD.
REQ-015 In PAD, the block SHALL emit px_data = 0 on consecutive cycles with indices k+1..INPUT_DIM-1, assert px_last on the final index, then move to WAIT.
REQ-016 In STREAM, a beat with idx = INPUT_DIM-1 and s_last = 0 (missing end) SHALL emit the pixel with px_last = 1, set frame_err, and move to DROP.
REQ-017 DROP SHALL discard accepted beats without driving px_valid, and SHALL move to WAIT on the accepted beat that has s_last = 1.
REQ-018 SHALL set a res_seen flag when res_valid = 1 in DROP or WAIT; res_valid in STREAM or PAD SHALL be ignored.
REQ-019 WAIT SHALL return to STREAM with idx = 0 in the cycle after res_valid = 1 or res_seen = 1; res_seen SHALL clear on that transition.
REQ-020 SHALL increment frame_cnt (wrapping 65535 -> 0) in the cycle px_last is driven high.
REQ-021 SHALL drive busy = 0 only when the state is STREAM and idx = 0.
REQ-022 err_clr SHALL clear frame_err; if a new error is set in the same cycle, frame_err SHALL remain 1.

Reset
REQ-023 rst = 1 SHALL force, at the next edge, state STREAM, idx = 0, res_seen = 0, px_valid = 0, px_data = 0, px_idx = 0, px_last = 0, frame_err = 0, frame_cnt = 0, busy = 0; s_ready then reads 1.
REQ-024 rst asserted mid-frame or in WAIT SHALL abandon the frame with no px_last emitted; the first beat after reset SHALL be index 0.

Verification
REQ-025 784 beats of s_data = 128, s_last on the last beat, no stalls -> px_data = 0 for idx 0..783, px_last only at idx 783, frame_cnt = 1, s_ready = 0 until res_valid.
REQ-026 s_data = 0, 255, 200 with FRAC_SHIFT = 2 -> px_data = -512, 508, 288.
REQ-027 s_last on beat idx 9 -> 10 data words, then 774 zero words on back-to-back cycles (idx 10..783), px_last at 783, frame_err = 1.
REQ-028 800-beat frame with s_last only on beat 800 -> px_last at idx 783, beats 785..800 dropped with no px_valid, res_valid pulsed during DROP -> return to STREAM without a further res_valid.
REQ-029 Random s_valid gaps -> px_idx strictly consecutive; rst asserted at idx 400 -> next frame starts at idx 0 and frame_cnt = 0; err_clr held high while an early s_last occurs -> frame_err = 1.

Source files
------------

// File: rtl/crystal_pixel_feeder.sv
// crystal_pixel_feeder
//
// Turns a raw 8-bit unsigned pixel stream into fixed-length frames of signed
// pixel words for a neural-network input layer. Each raw pixel has ZERO_POINT
// removed and is scaled by 2**FRAC_SHIFT. Malformed source frames are repaired:
//   - a frame that ends early is padded with zero words up to INPUT_DIM;
//   - a frame that runs long is cut at INPUT_DIM and the excess beats dropped.
// Both cases raise the sticky frame_err flag. After each delivered frame the
// feeder stalls the source until the network reports a result (res_valid).
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   s_valid    raw pixel beat valid
//   s_ready    feeder accepts a beat (STREAM and DROP only)
//   s_data     raw unsigned pixel
//   s_last     final beat of the source frame
//   res_valid  network result strobe
//   px_valid   registered pixel word valid
//   px_data    signed pixel word, DATA_WIDTH bits
//   px_idx     pixel index 0..INPUT_DIM-1
//   px_last    asserted with px_idx = INPUT_DIM-1
//   busy       low only when idle at the start of a frame
//   frame_err  sticky framing-error flag
//   err_clr    clears frame_err (a simultaneous new error wins)
//   frame_cnt  frames delivered to the network, wraps at 16 bits

module crystal_pixel_feeder #(
  parameter int unsigned INPUT_DIM  = 784,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ZERO_POINT = 128,
  // Legal range 0..DATA_WIDTH-9.
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [7:0]                   s_data,
  input  logic                         s_last,
  input  logic                         res_valid,
  output logic                         px_valid,
  output logic signed [DATA_WIDTH-1:0] px_data,
  output logic [$clog2(INPUT_DIM)-1:0] px_idx,
  output logic                         px_last,
  output logic                         busy,
  output logic                         frame_err,
  input  logic                         err_clr,
  output logic [15:0]                  frame_cnt
);

  localparam int unsigned IdxW = $clog2(INPUT_DIM);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(INPUT_DIM - 1);
  localparam logic [8:0] ZeroPoint9 = 9'(ZERO_POINT);

  typedef enum logic [1:0] {
    StStream,
    StPad,
    StDrop,
    StWait
  } state_e;

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic                          res_seen_q, res_seen_d;
  logic                          px_valid_q, px_valid_d;
  logic signed [DATA_WIDTH-1:0]  px_data_q, px_data_d;
  logic [IdxW-1:0]               px_idx_q, px_idx_d;
  logic                          px_last_q, px_last_d;
  logic                          frame_err_q, frame_err_d;
  logic [15:0]                   frame_cnt_q, frame_cnt_d;

  logic                          accept;
  logic                          err_set;
  logic signed [8:0]             centred;
  logic signed [DATA_WIDTH-1:0]  scaled;

  // Offset removal wraps in 9 bits, so every 8-bit input maps to -256..255
  // before sign extension; no saturation is applied after the shift.
  assign centred = $signed({1'b0, s_data} - ZeroPoint9);
  assign scaled  = DATA_WIDTH'(centred) <<< FRAC_SHIFT;

  assign s_ready = (state_q == StStream) || (state_q == StDrop);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    res_seen_d = res_seen_q;
    px_valid_d = 1'b0;
    px_data_d  = px_data_q;
    px_idx_d   = px_idx_q;
    px_last_d  = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      StStream: begin
        if (accept) begin
          px_valid_d = 1'b1;
          px_data_d  = scaled;
          px_idx_d   = idx_q;
          idx_d      = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            // Frame is full; a missing s_last means the tail must be dropped.
            px_last_d = 1'b1;
            idx_d     = '0;
            if (s_last) begin
              state_d = StWait;
            end else begin
              err_set = 1'b1;
              state_d = StDrop;
            end
          end else if (s_last) begin
            err_set = 1'b1;
            state_d = StPad;
          end
        end
      end

      StPad: begin
        // One zero word per cycle until the frame reaches INPUT_DIM.
        px_valid_d = 1'b1;
        px_data_d  = '0;
        px_idx_d   = idx_q;
        if (idx_q == LastIdx) begin
          px_last_d = 1'b1;
          idx_d     = '0;
          state_d   = StWait;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDrop: begin
        // The network may already answer while the source tail drains.
        if (res_valid) begin
          res_seen_d = 1'b1;
        end
        if (accept && s_last) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (res_valid || res_seen_q) begin
          state_d    = StStream;
          idx_d      = '0;
          res_seen_d = 1'b0;
        end
      end

      default: begin
        state_d = StStream;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (px_last_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    frame_err_d = frame_err_q;
    if (err_set) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StStream;
      idx_q       <= '0;
      res_seen_q  <= 1'b0;
      px_valid_q  <= 1'b0;
      px_data_q   <= '0;
      px_idx_q    <= '0;
      px_last_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_seen_q  <= res_seen_d;
      px_valid_q  <= px_valid_d;
      px_data_q   <= px_data_d;
      px_idx_q    <= px_idx_d;
      px_last_q   <= px_last_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign px_valid  = px_valid_q;
  assign px_data   = px_data_q;
  assign px_idx    = px_idx_q;
  assign px_last   = px_last_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = !((state_q == StStream) && (idx_q == '0));

endmodule

// File: tb/tb_crystal_pixel_feeder.sv
// Directed bench for crystal_pixel_feeder. A second instance with
// FRAC_SHIFT = 2 shares the stimulus so the scaled data path can be checked.

module tb_crystal_pixel_feeder;

  localparam int unsigned InputDim = 784;
  localparam int unsigned IdxW     = $clog2(InputDim);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              res_valid = 1'b0;
  logic              err_clr = 1'b0;

  logic              s_ready, px_valid, px_last, busy, frame_err;
  logic signed [15:0] px_data;
  logic [IdxW-1:0]   px_idx;
  logic [15:0]       frame_cnt;

  logic              sh_s_ready, sh_px_valid, sh_px_last, sh_busy, sh_frame_err;
  logic signed [15:0] sh_px_data;
  logic [IdxW-1:0]   sh_px_idx;
  logic [15:0]       sh_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream monitor state, written only by the monitor process.
  int n_px = 0, n_last = 0, n_nz = 0, seq_err = 0, last_bad = 0;
  int exp_idx = 0;

  crystal_pixel_feeder #(
    .INPUT_DIM (InputDim),
    .DATA_WIDTH(16),
    .ZERO_POINT(128),
    .FRAC_SHIFT(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .res_valid(res_valid),
    .px_valid (px_valid),
    .px_data  (px_data),
    .px_idx   (px_idx),
    .px_last  (px_last),
    .busy     (busy),
    .frame_err(frame_err),
    .err_clr  (err_clr),
    .frame_cnt(frame_cnt)
  );

  crystal_pixel_feeder #(
    .INPUT_DIM (InputDim),
    .DATA_WIDTH(16),
    .ZERO_POINT(128),
    .FRAC_SHIFT(2)
  ) dut_sh (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (sh_s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .res_valid(res_valid),
    .px_valid (sh_px_valid),
    .px_data  (sh_px_data),
    .px_idx   (sh_px_idx),
    .px_last  (sh_px_last),
    .busy     (sh_busy),
    .frame_err(sh_frame_err),
    .err_clr  (err_clr),
    .frame_cnt(sh_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      exp_idx = 0;
    end else if (px_valid) begin
      n_px++;
      if (px_data != 0) n_nz++;
      if (px_last) n_last++;
      if (int'(px_idx) != exp_idx) seq_err++;
      if (px_last != (int'(px_idx) == InputDim - 1)) last_bad++;
      exp_idx = px_last ? 0 : int'(px_idx) + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_res();
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    int snap_px, snap_last, snap_nz, pad_ok, acc, guard;
    logic v;

    // Reset state
    tick();
    tick();
    check_eq("rst_px_valid", int'(px_valid), 0);
    check_eq("rst_px_data", int'(px_data), 0);
    check_eq("rst_px_idx", int'(px_idx), 0);
    check_eq("rst_px_last", int'(px_last), 0);
    check_eq("rst_frame_err", int'(frame_err), 0);
    check_eq("rst_frame_cnt", int'(frame_cnt), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_s_ready", int'(s_ready), 1);
    rst = 1'b0;

    // Clean frame of mid-scale pixels; res_valid in STREAM must be ignored.
    snap_px = n_px; snap_last = n_last; snap_nz = n_nz;
    for (int i = 0; i < InputDim; i++) begin
      if (i == 300) res_valid = 1'b1;
      beat(8'd128, i == InputDim - 1);
      res_valid = 1'b0;
      if (i == 1) check_eq("a_busy_mid", int'(busy), 1);
    end
    check_eq("a_px_last", int'(px_last), 1);
    check_eq("a_px_idx_last", int'(px_idx), 783);
    check_eq("a_frame_cnt", int'(frame_cnt), 1);
    tick(); tick(); tick();
    check_eq("a_wait_s_ready", int'(s_ready), 0);
    check_eq("a_wait_busy", int'(busy), 1);
    check_eq("a_wait_px_valid", int'(px_valid), 0);
    pulse_res();
    check_eq("a_resume_s_ready", int'(s_ready), 1);
    check_eq("a_resume_busy", int'(busy), 0);
    check_eq("a_n_px", n_px - snap_px, 784);
    check_eq("a_n_last", n_last - snap_last, 1);
    check_eq("a_n_nonzero", n_nz - snap_nz, 0);

    // Early end at idx 9 -> zero padding for idx 10..783.
    snap_px = n_px; snap_nz = n_nz;
    for (int i = 0; i < 10; i++) begin
      beat(8'(130 + i), i == 9);
    end
    check_eq("b_data9", int'(px_data), 11);
    check_eq("b_idx9", int'(px_idx), 9);
    check_eq("b_last9", int'(px_last), 0);
    check_eq("b_frame_err", int'(frame_err), 1);
    check_eq("b_pad_s_ready", int'(s_ready), 0);
    pad_ok = 0;
    for (int k = 0; k < 774; k++) begin
      tick();
      if (px_valid && px_data == 0 && int'(px_idx) == 10 + k) pad_ok++;
    end
    check_eq("b_pad_words", pad_ok, 774);
    check_eq("b_pad_last", int'(px_last), 1);
    check_eq("b_frame_cnt", int'(frame_cnt), 2);
    tick();
    check_eq("b_wait_px_valid", int'(px_valid), 0);
    check_eq("b_wait_s_ready", int'(s_ready), 0);
    pulse_res();
    check_eq("b_resume_s_ready", int'(s_ready), 1);
    check_eq("b_n_px", n_px - snap_px, 784);
    check_eq("b_n_nonzero", n_nz - snap_nz, 10);

    // Clear the error, then an 800-beat frame with res_valid during DROP.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("c_err_cleared", int'(frame_err), 0);
    snap_px = n_px; snap_last = n_last;
    for (int i = 0; i < 800; i++) begin
      if (i == 790) res_valid = 1'b1;
      beat(8'd128, i == 799);
      res_valid = 1'b0;
      if (i == 783) begin
        check_eq("c_px_last", int'(px_last), 1);
        check_eq("c_frame_err", int'(frame_err), 1);
        check_eq("c_frame_cnt", int'(frame_cnt), 3);
      end
      if (i == 784) begin
        check_eq("c_drop_px_valid", int'(px_valid), 0);
        check_eq("c_drop_s_ready", int'(s_ready), 1);
      end
    end
    check_eq("c_wait_s_ready", int'(s_ready), 0);
    tick();
    check_eq("c_resume_s_ready", int'(s_ready), 1);
    check_eq("c_resume_busy", int'(busy), 0);
    check_eq("c_n_px", n_px - snap_px, 784);
    check_eq("c_n_last", n_last - snap_last, 1);

    // Data path: 0, 255, 200 unscaled and with FRAC_SHIFT = 2.
    beat(8'd0, 1'b0);
    check_eq("d_px0", int'(px_data), -128);
    check_eq("d_sh_px0", int'(sh_px_data), -512);
    beat(8'd255, 1'b0);
    check_eq("d_px1", int'(px_data), 127);
    check_eq("d_sh_px1", int'(sh_px_data), 508);
    beat(8'd200, 1'b1);
    check_eq("d_px2", int'(px_data), 72);
    check_eq("d_sh_px2", int'(sh_px_data), 288);
    repeat (781) tick();
    check_eq("d_pad_last", int'(px_last), 1);
    check_eq("d_frame_cnt", int'(frame_cnt), 4);
    pulse_res();

    // Random gaps, reset at idx 400, then err_clr racing an early end.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("e_err_cleared", int'(frame_err), 0);
    acc = 0;
    guard = 0;
    while (acc < 401 && guard < 5000) begin
      v = 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = 8'($urandom);
      s_last  = 1'b0;
      tick();
      if (v) acc++;
      guard++;
    end
    s_valid = 1'b0;
    check_eq("e_accepted", acc, 401);
    check_eq("e_px_idx400", int'(px_idx), 400);
    check_eq("e_seq_err", seq_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("e_rst_frame_cnt", int'(frame_cnt), 0);
    check_eq("e_rst_busy", int'(busy), 0);
    check_eq("e_rst_px_valid", int'(px_valid), 0);
    check_eq("e_rst_px_last", int'(px_last), 0);
    beat(8'd10, 1'b0);
    check_eq("e_first_idx", int'(px_idx), 0);
    check_eq("e_first_data", int'(px_data), -118);
    err_clr = 1'b1;
    beat(8'd20, 1'b1);
    check_eq("e_err_vs_clr", int'(frame_err), 1);
    err_clr = 1'b0;
    repeat (782) tick();
    check_eq("e_pad_last", int'(px_last), 1);
    check_eq("e_frame_cnt", int'(frame_cnt), 1);
    tick();
    check_eq("seq_err_total", seq_err, 0);
    check_eq("last_bad_total", last_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
